// File: rtl/stv_aes_pkg.sv
// Shared AES helpers: ShiftRows row-offset table and the ping-pong bank state encoding.
package stv_aes_pkg;

  typedef enum logic [1:0] {
    BkEmpty    = 2'd0,
    BkFilling  = 2'd1,
    BkFull     = 2'd2,
    BkDraining = 2'd3
  } bank_state_e;

  // Row offsets C_r, row 0 in the low slot.
  localparam logic [3:0][2:0] RowOffsetsNb46 = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [3:0][2:0] RowOffsetsNb8  = {3'd4, 3'd3, 3'd1, 3'd0};

  function automatic int unsigned row_offset(input int unsigned nb, input logic [1:0] row);
    logic [2:0] off;
    off = (nb == 8) ? RowOffsetsNb8[row] : RowOffsetsNb46[row];
    return int'(off);
  endfunction

  function automatic bit nb_legal(input int unsigned nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  function automatic bit lanes_legal(input int unsigned lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

endpackage

// File: rtl/stv_aes_shiftrows_nb.sv
// Combinational ShiftRows / InvShiftRows over a full column-major state of NB columns.
module stv_aes_shiftrows_nb
  import stv_aes_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic [4*NB-1:0][7:0] in_bytes,
  input  logic                 inverse,
  output logic [4*NB-1:0][7:0] out_bytes
);

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned Off    = row_offset(NB, 2'(r));
      localparam int unsigned FwdSrc = 4 * ((c + Off) % NB) + r;
      localparam int unsigned InvSrc = 4 * ((c + NB - Off) % NB) + r;
      assign out_bytes[4*c+r] = inverse ? in_bytes[InvSrc] : in_bytes[FwdSrc];
    end
  end

endmodule

// File: rtl/stv_aes_shiftrows_stream.sv
// Streaming ShiftRows with two ping-pong banks; each block keeps its first-beat direction.
// Optional per-block identity bypass: define STV_AES_SHIFTROWS_STREAM_BYPASS_EN.
module stv_aes_shiftrows_stream
  import stv_aes_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inverse,
`ifdef STV_AES_SHIFTROWS_STREAM_BYPASS_EN
  input  logic                 bypass_in,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last
);

  localparam int unsigned NBytes = 4 * NB;
  localparam int unsigned Beats  = NBytes / LANES;
  localparam int unsigned CntW   = $clog2(Beats);
  localparam int unsigned IdxW   = $clog2(NBytes);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("stv_aes_shiftrows_stream: NB must be 4, 6 or 8");
  end
  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("stv_aes_shiftrows_stream: LANES must be 1, 2 or 4");
  end

  bank_state_e                state_q [2];
  bank_state_e                state_d [2];
  logic [NBytes-1:0][7:0]     bank_q  [2];
  logic [1:0]                 inv_q;
  logic                       wr_bank_q, rd_bank_q;
  logic [CntW-1:0]            wr_cnt_q, rd_cnt_q;
  logic                       rdy_en_q;
  logic                       in_fire, out_fire, wr_last, rd_last;
  logic [NBytes-1:0][7:0]     rd_bytes, perm_bytes, disp_bytes;
  logic [8*LANES-1:0]         beat_data;

  assign wr_last = (wr_cnt_q == CntW'(Beats - 1));
  assign rd_last = (rd_cnt_q == CntW'(Beats - 1));

  // Handshake status depends only on registered bank state.
  always_comb begin
    in_ready  = rdy_en_q &&
                ((state_q[wr_bank_q] == BkEmpty) || (state_q[wr_bank_q] == BkFilling));
    out_valid = (state_q[rd_bank_q] == BkFull) || (state_q[rd_bank_q] == BkDraining);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    for (int b = 0; b < 2; b++) begin
      if (in_fire && (wr_bank_q == 1'(b))) begin
        state_d[b] = wr_last ? BkFull : BkFilling;
      end
      if (out_fire && (rd_bank_q == 1'(b))) begin
        state_d[b] = rd_last ? BkEmpty : BkDraining;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= BkEmpty;
      state_q[1] <= BkEmpty;
      inv_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      if (in_fire) begin
        if (wr_cnt_q == '0) begin
          inv_q[wr_bank_q] <= in_inverse;
        end
        wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
        if (wr_last) begin
          wr_bank_q <= ~wr_bank_q;
        end
      end
      if (out_fire) begin
        rd_cnt_q <= rd_last ? '0 : rd_cnt_q + 1'b1;
        if (rd_last) begin
          rd_bank_q <= ~rd_bank_q;
        end
      end
    end
  end

  // Payload storage needs no reset; outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < int'(LANES); k++) begin
        bank_q[wr_bank_q][IdxW'(int'(wr_cnt_q) * int'(LANES) + k)] <= in_data[8*k +: 8];
      end
    end
  end

  assign rd_bytes = bank_q[rd_bank_q];

  stv_aes_shiftrows_nb #(
    .NB (NB)
  ) u_shiftrows (
    .in_bytes  (rd_bytes),
    .inverse   (inv_q[rd_bank_q]),
    .out_bytes (perm_bytes)
  );

`ifdef STV_AES_SHIFTROWS_STREAM_BYPASS_EN
  logic [1:0] byp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= '0;
    end else if (in_fire && (wr_cnt_q == '0)) begin
      byp_q[wr_bank_q] <= bypass_in;
    end
  end

  assign disp_bytes = byp_q[rd_bank_q] ? rd_bytes : perm_bytes;
`else
  assign disp_bytes = perm_bytes;
`endif

  always_comb begin
    beat_data = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      beat_data[8*k +: 8] = disp_bytes[IdxW'(int'(rd_cnt_q) * int'(LANES) + k)];
    end
  end

  assign out_data = out_valid ? beat_data : '0;
  assign out_last = out_valid && rd_last;

endmodule

// File: tb/tb_stv_aes_shiftrows_stream.sv
// Directed bench: NB=4/LANES=4 vector table, backpressure, mid-block reset, and NB=8 block.
module tb_stv_aes_shiftrows_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid4, in_ready4, in_inverse4, out_valid4, out_ready4, out_last4;
  logic [31:0] in_data4, out_data4;
  logic        in_valid8, in_ready8, in_inverse8, out_valid8, out_ready8, out_last8;
  logic [31:0] in_data8, out_data8;

  stv_aes_shiftrows_stream #(.NB(4), .LANES(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .in_data    (in_data4),
    .in_inverse (in_inverse4),
`ifdef STV_AES_SHIFTROWS_STREAM_BYPASS_EN
    .bypass_in  (1'b0),
`endif
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .out_data   (out_data4),
    .out_last   (out_last4)
  );

  stv_aes_shiftrows_stream #(.NB(8), .LANES(4)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .in_data    (in_data8),
    .in_inverse (in_inverse8),
`ifdef STV_AES_SHIFTROWS_STREAM_BYPASS_EN
    .bypass_in  (1'b0),
`endif
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .out_data   (out_data8),
    .out_last   (out_last8)
  );

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] exp8 [8];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-first beats carry the opposite direction, which the DUT must ignore.
  task automatic send_beats4(input logic inv, input logic [127:0] blk, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      int n;
      in_valid4   = 1'b1;
      in_data4    = blk[32*b +: 32];
      in_inverse4 = (b == 0) ? inv : ~inv;
      n = 0;
      while (!in_ready4 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready4) chk($sformatf("send_ready_b%0d", b), 32'(in_ready4), 32'd1);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
  endtask

  task automatic recv_block4(input logic [127:0] exp, input string tag);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s_valid%0d", tag, b), 32'(out_valid4), 32'd1);
      chk($sformatf("%s_data%0d", tag, b), out_data4, exp[32*b +: 32]);
      chk($sformatf("%s_last%0d", tag, b), 32'(out_last4), 32'(b == 3));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int acc, got, blk, bt;
    logic rdy;

    vecs[0] = '{1'b0, 128'h0F0E0D0C0B0A09080706050403020100,
                      128'h0B06010C07020D08030E09040F0A0500};
    vecs[1] = '{1'b1, 128'h0F0E0D0C0B0A09080706050403020100,
                      128'h0306090C0F0205080B0E0104070A0D00};
    vecs[2] = '{1'b0, 128'h3F3E3D3C3B3A39383736353433323130,
                      128'h3B36313C37323D38333E39343F3A3530};
    vecs[3] = '{1'b1, 128'h3F3E3D3C3B3A39383736353433323130,
                      128'h3336393C3F3235383B3E3134373A3D30};
    exp8 = '{32'h130E0500, 32'h17120904, 32'h1B160D08, 32'h1F1A110C,
             32'h031E1510, 32'h07021914, 32'h0B061D18, 32'h0F0A011C};

    rst_n = 1'b0;
    in_valid4 = 0; in_data4 = '0; in_inverse4 = 0; out_ready4 = 1;
    in_valid8 = 0; in_data8 = '0; in_inverse8 = 0; out_ready8 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready4), 32'd0);
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_data", out_data4, 32'd0);
    chk("rst_out_last", 32'(out_last4), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre_edge", 32'(in_ready4), 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_post_edge", 32'(in_ready4), 32'd1);

    // Vector table: out_valid must be high the cycle after the last accepted beat.
    for (int i = 0; i < 4; i++) begin
      send_beats4(vecs[i].inv, vecs[i].din, 4);
      recv_block4(vecs[i].dout, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_idle", i), 32'(out_valid4), 32'd0);
    end

    // Three blocks with the sink stalled: only two banks' worth accepted.
    out_ready4 = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      blk = acc / 4; bt = acc % 4;
      in_valid4   = 1'b1;
      in_data4    = vecs[blk].din[32*bt +: 32];
      in_inverse4 = (bt == 0) ? vecs[blk].inv : ~vecs[blk].inv;
      rdy = in_ready4;
      @(posedge clk); #1;
      if (rdy) acc++;
      if (cyc == 5) chk("bp_hold_early", out_data4, vecs[0].dout[31:0]);
    end
    chk("bp_accepted", 32'(acc), 32'd8);
    chk("bp_in_ready_low", 32'(in_ready4), 32'd0);
    chk("bp_hold_late", out_data4, vecs[0].dout[31:0]);
    chk("bp_hold_last", 32'(out_last4), 32'd0);

    out_ready4 = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      blk = acc / 4; bt = acc % 4;
      in_valid4 = (acc < 12);
      if (acc < 12) begin
        in_data4    = vecs[blk].din[32*bt +: 32];
        in_inverse4 = (bt == 0) ? vecs[blk].inv : ~vecs[blk].inv;
      end
      chk($sformatf("bp_out_valid%0d", got), 32'(out_valid4), 32'd1);
      chk($sformatf("bp_out_data%0d", got), out_data4, vecs[got/4].dout[32*(got%4) +: 32]);
      chk($sformatf("bp_out_last%0d", got), 32'(out_last4), 32'((got % 4) == 3));
      rdy = in_ready4 && in_valid4;
      @(posedge clk); #1;
      if (rdy) acc++;
      got++;
    end
    in_valid4 = 1'b0;
    chk("bp_all_in", 32'(acc), 32'd12);
    chk("bp_drained", 32'(out_valid4), 32'd0);

    // Reset with one full block pending and a partial block in the other bank.
    out_ready4 = 1'b0;
    send_beats4(vecs[1].inv, vecs[1].din, 4);
    send_beats4(vecs[2].inv, vecs[2].din, 2);
    chk("prerst_out_valid", 32'(out_valid4), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid4), 32'd0);
    chk("midrst_out_data", out_data4, 32'd0);
    chk("midrst_out_last", 32'(out_last4), 32'd0);
    chk("midrst_in_ready", 32'(in_ready4), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", 32'(in_ready4), 32'd1);
    chk("postrst_out_valid", 32'(out_valid4), 32'd0);
    out_ready4 = 1'b1;
    send_beats4(vecs[3].inv, vecs[3].din, 4);
    recv_block4(vecs[3].dout, "postrst");

    // NB=8: 32-byte block, offsets (0,1,3,4).
    for (int b = 0; b < 8; b++) begin
      int n;
      in_valid8   = 1'b1;
      in_inverse8 = (b == 0) ? 1'b0 : 1'b1;
      in_data8    = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
      n = 0;
      while (!in_ready8 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready8) chk($sformatf("nb8_ready%0d", b), 32'(in_ready8), 32'd1);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("nb8_valid%0d", b), 32'(out_valid8), 32'd1);
      chk($sformatf("nb8_data%0d", b), out_data8, exp8[b]);
      chk($sformatf("nb8_last%0d", b), 32'(out_last8), 32'(b == 7));
      @(posedge clk); #1;
    end
    chk("nb8_idle", 32'(out_valid8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
